// File: rtl/qc_ldpc_bitflip_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : qc_ldpc_bitflip_decoder_if
// Description : Handshake / data bundle for the QC-LDPC bit-flipping decoder.
//               The master drives the received bit stream and the circulant
//               first rows; the slave (decoder) returns status and the word.
// Revision    : 1.0 - initial release
// ============================================================================
interface qc_ldpc_bitflip_decoder_if;
    logic        start;
    logic        data_valid;
    logic        data_in;
    logic [31:0] H_row_1;
    logic [31:0] H_row_2;
    logic        busy;
    logic        done;
    logic        success;
    logic [3:0]  iter_count;
    logic [63:0] decoded_word;

    modport master (
        output start, data_valid, data_in, H_row_1, H_row_2,
        input  busy, done, success, iter_count, decoded_word
    );

    modport slave (
        input  start, data_valid, data_in, H_row_1, H_row_2,
        output busy, done, success, iter_count, decoded_word
    );
endinterface
`default_nettype wire

// File: rtl/qc_ldpc_bitflip_decoder.sv
`default_nettype none
// ============================================================================
// Module      : qc_ldpc_bitflip_decoder
// Description : Hard-decision Gallager bit-flipping decoder for the 64-bit
//               two-circulant QC-LDPC code H = [C1 | C2]. Loads the word
//               bit-serially while accumulating the syndrome, then runs
//               serial flip sweeps until the syndrome clears or MAX_ITER
//               sweeps have been spent.
//               Optional feature macro: QC_LDPC_DEC_EARLY_EXIT_EN - end a
//               sweep as soon as a flip drives the syndrome to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module qc_ldpc_bitflip_decoder #(
    parameter int MAX_ITER    = 8,
    parameter int FLIP_THRESH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    qc_ldpc_bitflip_decoder_if.slave bus
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_LOAD  = 3'd1;
    localparam logic [2:0] c_ST_CHECK = 3'd2;
    localparam logic [2:0] c_ST_FLIP  = 3'd3;
    localparam logic [2:0] c_ST_DONE  = 3'd4;

    localparam logic [3:0] c_MAX_ITER = 4'(MAX_ITER);
    localparam logic [5:0] c_THRESH   = 6'(FLIP_THRESH);
    localparam logic [5:0] c_LAST_BIT = 6'd63;

    logic [2:0]  r_state;
    logic [5:0]  r_index;
    logic [31:0] r_syndrome;
    logic [63:0] r_word;
    logic [3:0]  r_iter;
    logic        r_busy;
    logic        r_done;
    logic        r_success;

    logic [31:0] w_row;
    logic [31:0] w_col;
    logic [31:0] w_hits;
    logic [31:0] w_syn_toggled;
    logic [5:0]  w_cnt;
    logic        w_flip;
    logic        w_sweep_end;

    // The current bit index selects which circulant supplies its column.
    assign w_row = r_index[5] ? bus.H_row_2 : bus.H_row_1;

    // Column m of a circulant is its first row read backwards from bit m,
    // so check r of the column is row bit (m - r) mod 32.
    generate
        for (genvar r = 0; r < 32; r++) begin : g_col
            assign w_col[r] = w_row[r_index[4:0] - 5'(r)];
        end
    endgenerate

    assign w_hits        = r_syndrome & w_col;
    assign w_syn_toggled = r_syndrome ^ w_col;

    // Count of unsatisfied checks touching the current bit.
    always_comb begin
        w_cnt = 6'd0;
        for (int i = 0; i < 32; i++) begin
            w_cnt = w_cnt + 6'(w_hits[i]);
        end
    end

    assign w_flip = (w_cnt >= c_THRESH);

`ifdef QC_LDPC_DEC_EARLY_EXIT_EN
    // A flip that clears the syndrome makes the rest of the sweep pointless.
    assign w_sweep_end = (r_index == c_LAST_BIT) || (w_flip && (w_syn_toggled == 32'd0));
`else
    assign w_sweep_end = (r_index == c_LAST_BIT);
`endif

    // Decoder control FSM together with its datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_ST_IDLE;
            r_index    <= 6'd0;
            r_syndrome <= 32'd0;
            r_word     <= 64'd0;
            r_iter     <= 4'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_success  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    if (bus.start) begin
                        r_state    <= c_ST_LOAD;
                        r_busy     <= 1'b1;
                        r_success  <= 1'b0;
                        r_iter     <= 4'd0;
                        r_word     <= 64'd0;
                        r_syndrome <= 32'd0;
                        r_index    <= 6'd0;
                    end else begin
                        r_state <= c_ST_IDLE;
                    end
                end
                c_ST_LOAD: begin
                    if (bus.data_valid) begin
                        r_word[r_index] <= bus.data_in;
                        if (bus.data_in) begin
                            r_syndrome <= w_syn_toggled;
                        end
                        r_index <= r_index + 6'd1;
                        if (r_index == c_LAST_BIT) begin
                            r_state <= c_ST_CHECK;
                        end
                    end
                end
                c_ST_CHECK: begin
                    if (r_syndrome == 32'd0) begin
                        r_state   <= c_ST_DONE;
                        r_success <= 1'b1;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                    end else if (r_iter == c_MAX_ITER) begin
                        r_state   <= c_ST_DONE;
                        r_success <= 1'b0;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                    end else begin
                        r_state <= c_ST_FLIP;
                        r_index <= 6'd0;
                    end
                end
                c_ST_FLIP: begin
                    if (w_flip) begin
                        r_word[r_index] <= ~r_word[r_index];
                        r_syndrome      <= w_syn_toggled;
                    end
                    r_index <= r_index + 6'd1;
                    if (w_sweep_end) begin
                        r_iter  <= r_iter + 4'd1;
                        r_state <= c_ST_CHECK;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.success      = r_success;
    assign bus.iter_count   = r_iter;
    assign bus.decoded_word = r_word;

endmodule
`default_nettype wire

// File: tb/tb_qc_ldpc_bitflip_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_qc_ldpc_bitflip_decoder
// Description : Self-checking bench for qc_ldpc_bitflip_decoder. Two decoders
//               (MAX_ITER 8 and 2) share one stimulus stream; results are
//               checked against a matrix-level bit-flipping reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qc_ldpc_bitflip_decoder;

    localparam int c_FLIP_THRESH = 2;
    localparam int c_TIMEOUT     = 3000;
`ifdef QC_LDPC_DEC_EARLY_EXIT_EN
    localparam bit c_EARLY  = 1'b1;
    localparam int c_SE_LAT = 73;
`else
    localparam bit c_EARLY  = 1'b0;
    localparam int c_SE_LAT = 131;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    qc_ldpc_bitflip_decoder_if ifc0 ();
    qc_ldpc_bitflip_decoder_if ifc1 ();

    // Second decoder sees exactly the same inputs as the first.
    assign ifc1.start      = ifc0.start;
    assign ifc1.data_valid = ifc0.data_valid;
    assign ifc1.data_in    = ifc0.data_in;
    assign ifc1.H_row_1    = ifc0.H_row_1;
    assign ifc1.H_row_2    = ifc0.H_row_2;

    qc_ldpc_bitflip_decoder #(.MAX_ITER(8), .FLIP_THRESH(c_FLIP_THRESH)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc0.slave)
    );

    qc_ldpc_bitflip_decoder #(.MAX_ITER(2), .FLIP_THRESH(c_FLIP_THRESH)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc1.slave)
    );

    int tests = 0;
    int fails = 0;

    // Observations from the most recent decode, index 0 = dut0, 1 = dut1.
    int          o_lat[2];
    logic        o_succ[2];
    logic [3:0]  o_iter[2];
    logic [63:0] o_word[2];
    logic        o_busy_rise[2];
    logic        o_busy_after[2];
    logic        o_done_after[2];

    // Model predictions for the same decode.
    bit          e_succ[2];
    int          e_iter[2];
    logic [63:0] e_word[2];
    int          e_lat[2];

    // Snapshot of outputs for direct checks.
    logic        s_busy[2];
    logic        s_done[2];
    logic        s_succ[2];
    logic [3:0]  s_iter[2];
    logic [63:0] s_word[2];

    // Reference: build H row by row, compute the syndrome as H*x, then apply
    // Gallager sweeps; latency is accumulated from the cycle cost of each phase.
    task automatic model(input logic [63:0] w, input logic [31:0] ha, input logic [31:0] hb,
                         input int max_iter, input bit stall, output bit succ, output int iters,
                         output logic [63:0] dw, output int lat);
        bit hm[32][64];
        bit syn[32];
        bit any;
        bit stop;
        int cnt;
        int col;
        int cyc;
        for (int r = 0; r < 32; r++) begin
            for (int c = 0; c < 64; c++) begin
                col = ((c % 32) - r + 32) % 32;
                hm[r][c] = (c < 32) ? ha[col] : hb[col];
            end
        end
        for (int r = 0; r < 32; r++) begin
            syn[r] = 1'b0;
            for (int c = 0; c < 64; c++) syn[r] ^= hm[r][c] & w[c];
        end
        dw    = w;
        iters = 0;
        succ  = 1'b0;
        cyc   = (stall ? 127 : 64) + 2;
        while (1) begin
            any = 1'b0;
            for (int r = 0; r < 32; r++) any |= syn[r];
            if (!any) begin
                succ = 1'b1;
                break;
            end
            if (iters == max_iter) break;
            stop = 1'b0;
            for (int j = 0; j < 64 && !stop; j++) begin
                cnt = 0;
                for (int r = 0; r < 32; r++) cnt += (hm[r][j] && syn[r]) ? 1 : 0;
                if (cnt >= c_FLIP_THRESH) begin
                    dw[j] = ~dw[j];
                    for (int r = 0; r < 32; r++) syn[r] ^= hm[r][j];
                    if (c_EARLY) begin
                        any = 1'b0;
                        for (int r = 0; r < 32; r++) any |= syn[r];
                        if (!any) begin
                            stop = 1'b1;
                            cyc += j + 1;
                        end
                    end
                end
            end
            if (!stop) cyc += 64;
            cyc   += 1;
            iters += 1;
        end
        lat = cyc;
    endtask

    task automatic predict(input logic [63:0] w, input bit stall);
        model(w, ifc0.H_row_1, ifc0.H_row_2, 8, stall, e_succ[0], e_iter[0], e_word[0], e_lat[0]);
        model(w, ifc0.H_row_1, ifc0.H_row_2, 2, stall, e_succ[1], e_iter[1], e_word[1], e_lat[1]);
    endtask

    task automatic snap();
        s_busy[0] = ifc0.busy;       s_busy[1] = ifc1.busy;
        s_done[0] = ifc0.done;       s_done[1] = ifc1.done;
        s_succ[0] = ifc0.success;    s_succ[1] = ifc1.success;
        s_iter[0] = ifc0.iter_count; s_iter[1] = ifc1.iter_count;
        s_word[0] = ifc0.decoded_word; s_word[1] = ifc1.decoded_word;
    endtask

    // Drive one start + 64-bit load (optionally stalled, optionally with a
    // stray start pulse) and record what both decoders report. Latency counts
    // cycles from the start cycle (cycle 0) to the cycle done is seen.
    task automatic run_decode(input logic [63:0] w, input bit stall, input int glitch_at);
        int nbit;
        int c;
        for (int k = 0; k < 2; k++) begin
            o_lat[k] = -1;
            o_succ[k] = 1'bx; o_iter[k] = 4'bx; o_word[k] = 64'bx;
            o_busy_rise[k] = 1'bx; o_busy_after[k] = 1'bx; o_done_after[k] = 1'bx;
        end
        @(negedge clk);
        ifc0.start = 1'b1;
        ifc0.data_valid = 1'b0;
        nbit = 0;
        c = 0;
        while (c < c_TIMEOUT) begin
            @(negedge clk);
            c++;
            snap();
            for (int k = 0; k < 2; k++) begin
                if (c == 1) o_busy_rise[k] = s_busy[k];
                if (o_lat[k] < 0 && s_done[k]) begin
                    o_lat[k] = c; o_succ[k] = s_succ[k]; o_iter[k] = s_iter[k]; o_word[k] = s_word[k];
                end else if (o_lat[k] > 0 && c == o_lat[k] + 1) begin
                    o_busy_after[k] = s_busy[k];
                    o_done_after[k] = s_done[k];
                end
            end
            if (o_lat[0] > 0 && o_lat[1] > 0 && c > o_lat[0] && c > o_lat[1]) break;
            ifc0.start = (c == glitch_at);
            if (nbit < 64 && (!stall || c[0])) begin
                ifc0.data_valid = 1'b1;
                ifc0.data_in = w[nbit];
                nbit++;
            end else begin
                ifc0.data_valid = 1'b0;
                ifc0.data_in = 1'b0;
            end
        end
        ifc0.start = 1'b0;
        ifc0.data_valid = 1'b0;
        ifc0.data_in = 1'b0;
    endtask

    task automatic test_reset();
        snap();
        for (int k = 0; k < 2; k++) begin
            tests++; if (s_busy[k] !== 1'b0) begin fails++; $display("FAIL reset_busy dut%0d: got %b, expected 0", k, s_busy[k]); end
            tests++; if (s_done[k] !== 1'b0) begin fails++; $display("FAIL reset_done dut%0d: got %b, expected 0", k, s_done[k]); end
            tests++; if (s_succ[k] !== 1'b0) begin fails++; $display("FAIL reset_success dut%0d: got %b, expected 0", k, s_succ[k]); end
            tests++; if (s_iter[k] !== 4'd0) begin fails++; $display("FAIL reset_iter dut%0d: got %0d, expected 0", k, s_iter[k]); end
            tests++; if (s_word[k] !== 64'd0) begin fails++; $display("FAIL reset_word dut%0d: got %h, expected 0", k, s_word[k]); end
        end
    endtask

    task automatic test_clean();
        run_decode(64'd0, 1'b0, -1);
        for (int k = 0; k < 2; k++) begin
            tests++; if (o_lat[k] !== 66) begin fails++; $display("FAIL clean_latency dut%0d: got %0d, expected 66", k, o_lat[k]); end
            tests++; if (o_succ[k] !== 1'b1) begin fails++; $display("FAIL clean_success dut%0d: got %b, expected 1", k, o_succ[k]); end
            tests++; if (o_iter[k] !== 4'd0) begin fails++; $display("FAIL clean_iter dut%0d: got %0d, expected 0", k, o_iter[k]); end
            tests++; if (o_word[k] !== 64'd0) begin fails++; $display("FAIL clean_word dut%0d: got %h, expected 0", k, o_word[k]); end
            tests++; if (o_busy_rise[k] !== 1'b1) begin fails++; $display("FAIL clean_busy_rise dut%0d: got %b, expected 1", k, o_busy_rise[k]); end
            tests++; if (o_busy_after[k] !== 1'b0 || o_done_after[k] !== 1'b0) begin fails++;
                $display("FAIL clean_after_done dut%0d: got busy %b done %b, expected 0 0", k, o_busy_after[k], o_done_after[k]); end
        end
    endtask

    task automatic test_single_error();
        run_decode(64'h0000_0000_0000_0020, 1'b0, -1);
        for (int k = 0; k < 2; k++) begin
            tests++; if (o_lat[k] !== c_SE_LAT) begin fails++; $display("FAIL single_latency dut%0d: got %0d, expected %0d", k, o_lat[k], c_SE_LAT); end
            tests++; if (o_succ[k] !== 1'b1) begin fails++; $display("FAIL single_success dut%0d: got %b, expected 1", k, o_succ[k]); end
            tests++; if (o_iter[k] !== 4'd1) begin fails++; $display("FAIL single_iter dut%0d: got %0d, expected 1", k, o_iter[k]); end
            tests++; if (o_word[k] !== 64'd0) begin fails++; $display("FAIL single_word dut%0d: got %h, expected 0", k, o_word[k]); end
        end
    endtask

    task automatic test_stall();
        run_decode(64'd0, 1'b1, -1);
        for (int k = 0; k < 2; k++) begin
            tests++; if (o_lat[k] !== 129) begin fails++; $display("FAIL stall_latency dut%0d: got %0d, expected 129", k, o_lat[k]); end
            tests++; if (o_succ[k] !== 1'b1) begin fails++; $display("FAIL stall_success dut%0d: got %b, expected 1", k, o_succ[k]); end
            tests++; if (o_iter[k] !== 4'd0 || o_word[k] !== 64'd0) begin fails++;
                $display("FAIL stall_result dut%0d: got iter %0d word %h, expected 0 0", k, o_iter[k], o_word[k]); end
        end
    endtask

    task automatic test_uncorrectable();
        logic [63:0] w;
        w = 64'h0000_0003_0000_000F;
        predict(w, 1'b0);
        run_decode(w, 1'b0, -1);
        tests++; if (o_succ[1] !== 1'b0) begin fails++; $display("FAIL uncorr_success dut1: got %b, expected 0", o_succ[1]); end
        tests++; if (o_iter[1] !== 4'd2) begin fails++; $display("FAIL uncorr_iter dut1: got %0d, expected 2", o_iter[1]); end
        for (int k = 0; k < 2; k++) begin
            tests++; if (o_busy_after[k] !== 1'b0) begin fails++; $display("FAIL uncorr_busy_after dut%0d: got %b, expected 0", k, o_busy_after[k]); end
            tests++; if (o_succ[k] !== e_succ[k] || o_iter[k] !== 4'(e_iter[k])) begin fails++;
                $display("FAIL uncorr_status dut%0d: got succ %b iter %0d, expected %b %0d", k, o_succ[k], o_iter[k], e_succ[k], e_iter[k]); end
            tests++; if (o_word[k] !== e_word[k]) begin fails++; $display("FAIL uncorr_word dut%0d: got %h, expected %h", k, o_word[k], e_word[k]); end
            tests++; if (o_lat[k] !== e_lat[k]) begin fails++; $display("FAIL uncorr_latency dut%0d: got %0d, expected %0d", k, o_lat[k], e_lat[k]); end
        end
    endtask

    task automatic test_reset_mid_flip();
        logic [63:0] w;
        w = 64'h0000_0003_0000_000F;
        @(negedge clk);
        ifc0.start = 1'b1;
        // Cycle 150 lies inside the second sweep of both decoders.
        for (int c = 1; c <= 150; c++) begin
            @(negedge clk);
            ifc0.start = 1'b0;
            ifc0.data_valid = (c <= 64);
            ifc0.data_in = (c <= 64) ? w[c-1] : 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        snap();
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tests++; if (s_busy[k] !== 1'b0 || s_done[k] !== 1'b0 || s_succ[k] !== 1'b0) begin fails++;
                $display("FAIL midflip_flags dut%0d: got busy %b done %b succ %b, expected 0 0 0", k, s_busy[k], s_done[k], s_succ[k]); end
            tests++; if (s_iter[k] !== 4'd0) begin fails++; $display("FAIL midflip_iter dut%0d: got %0d, expected 0", k, s_iter[k]); end
            tests++; if (s_word[k] !== 64'd0) begin fails++; $display("FAIL midflip_word dut%0d: got %h, expected 0", k, s_word[k]); end
        end
        run_decode(64'd0, 1'b0, -1);
        for (int k = 0; k < 2; k++) begin
            tests++; if (o_lat[k] !== 66 || o_succ[k] !== 1'b1 || o_iter[k] !== 4'd0) begin fails++;
                $display("FAIL post_reset_decode dut%0d: got lat %0d succ %b iter %0d, expected 66 1 0", k, o_lat[k], o_succ[k], o_iter[k]); end
        end
    endtask

    task automatic test_start_during_load();
        logic [63:0] w;
        w = 64'd0;
        w[$urandom_range(0, 63)] = 1'b1;
        w[$urandom_range(0, 63)] = 1'b1;
        predict(w, 1'b0);
        run_decode(w, 1'b0, 10);
        for (int k = 0; k < 2; k++) begin
            tests++; if (o_lat[k] !== e_lat[k]) begin fails++; $display("FAIL glitch_latency dut%0d: got %0d, expected %0d", k, o_lat[k], e_lat[k]); end
            tests++; if (o_succ[k] !== e_succ[k] || o_iter[k] !== 4'(e_iter[k])) begin fails++;
                $display("FAIL glitch_status dut%0d: got succ %b iter %0d, expected %b %0d", k, o_succ[k], o_iter[k], e_succ[k], e_iter[k]); end
            tests++; if (o_word[k] !== e_word[k]) begin fails++; $display("FAIL glitch_word dut%0d: got %h, expected %h", k, o_word[k], e_word[k]); end
        end
    endtask

    task automatic test_random();
        logic [63:0] w;
        bit stall;
        for (int n = 0; n < 8; n++) begin
            ifc0.H_row_1 = $urandom;
            ifc0.H_row_2 = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                w = {$urandom, $urandom};
            end else begin
                w = 64'd0;
                repeat ($urandom_range(1, 4)) w[$urandom_range(0, 63)] = 1'b1;
            end
            stall = 1'($urandom_range(0, 1));
            predict(w, stall);
            run_decode(w, stall, -1);
            for (int k = 0; k < 2; k++) begin
                tests++; if (o_lat[k] !== e_lat[k]) begin fails++;
                    $display("FAIL random%0d_latency dut%0d: got %0d, expected %0d", n, k, o_lat[k], e_lat[k]); end
                tests++; if (o_succ[k] !== e_succ[k] || o_iter[k] !== 4'(e_iter[k])) begin fails++;
                    $display("FAIL random%0d_status dut%0d: got succ %b iter %0d, expected %b %0d", n, k, o_succ[k], o_iter[k], e_succ[k], e_iter[k]); end
                tests++; if (o_word[k] !== e_word[k]) begin fails++;
                    $display("FAIL random%0d_word dut%0d: got %h, expected %h", n, k, o_word[k], e_word[k]); end
            end
        end
    endtask

    initial begin
        ifc0.start      = 1'b0;
        ifc0.data_valid = 1'b0;
        ifc0.data_in    = 1'b0;
        ifc0.H_row_1    = 32'h0000_000B;
        ifc0.H_row_2    = 32'h0000_0015;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b0;
        test_clean();
        test_single_error();
        test_stall();
        test_uncorrectable();
        test_reset_mid_flip();
        test_start_during_load();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/qc_ldpc_bitflip_decoder.md
# qc_ldpc_bitflip_decoder

Hard-decision bit-flipping decoder for the 64-bit, two-circulant QC-LDPC code. Parity-check matrix H = [C1 | C2], each a 32x32 circulant defined by its first row. Accepts a received word bit-serially, builds the 32-bit syndrome on the fly with a shift-register accumulator, then runs serial Gallager bit-flipping sweeps until the syndrome clears or the iteration budget runs out. It sits at the receive end of the encoder data path and consumes the same bit-serial stream.

## Interface
- MAX_ITER, 8, maximum flip sweeps before giving up (1..15)
- FLIP_THRESH, 2, unsatisfied-check count at or above which a bit is flipped
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; begins a new word (ignored unless IDLE/DONE)
- data_valid  in  1  qualifies data_in during load
- data_in  in  1  received bit, codeword index 0 first
- H_row_1  in  32  first row of C1, bit c = column c; stable while busy
- H_row_2  in  32  first row of C2
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at decode end
- success  out  1  final syndrome zero; valid from done, held until next start
- iter_count  out  4  sweeps performed; held like success
- decoded_word  out  64  bit i = codeword index i; held like success

## Operation
- Column vector of bit j (block k = j/32, m = j%32, row h = H_row_k): bit r = h[(m - r) mod 32].
- States: IDLE, LOAD, CHECK, FLIP, DONE.
- IDLE/DONE --start--> LOAD: clear syndrome, word, bit index, iter_count.
- LOAD: each cycle with data_valid, store bit at index, syndrome ^= col_vec(index) if bit=1, index++. data_valid low stalls. After index 63 -> CHECK.
- CHECK (1 cycle): syndrome==0 -> DONE, success=1. Else iter_count==MAX_ITER -> DONE, success=0. Else -> FLIP, index=0.
- FLIP: one bit per cycle, j=0..63. cnt = popcount(syndrome & col_vec(j)), 6 bits. cnt >= FLIP_THRESH -> toggle word[j], syndrome ^= col_vec(j), same cycle. Later bits see the updated syndrome. After j=63: iter_count++, -> CHECK.
- DONE: done=1 for this cycle only, then IDLE. Outputs hold until the next start.
- start while busy: ignored. reset at any point: IDLE, all outputs and internal state 0.

## Timing
- Reset values: busy=0, done=0, success=0, iter_count=0, decoded_word=0.
- busy rises the cycle after start is sampled.
- Load = 64 valid cycles. Each sweep = 64 cycles. CHECK = 1 cycle.
- Clean word, no stalls: done is 66 cycles after start (64 load + CHECK + DONE).
- Each sweep adds 65 cycles.
- Syndrome and word updates are registered. The popcount and compare are combinational within the cycle.

## Configuration
- QC_LDPC_DEC_EARLY_EXIT_EN defined: in FLIP, if the post-update syndrome is zero, the sweep ends immediately. iter_count++, go to CHECK next cycle.
- Undefined: every sweep runs all 64 bits. Decoded result is identical either way; only latency differs.

## Test plan
- H_row_1=32'h0000000B, H_row_2=32'h00000015, all-zero word, no stalls -> done 66 cycles after start, success=1, iter_count=0, decoded_word=0.
- Same H, single error at index 5 (syndrome 32'h00000034) -> bit 5 flipped in sweep 1, success=1, iter_count=1, decoded_word=0.
  - Without EARLY_EXIT, done at cycle 131.
  - With EARLY_EXIT, done 6 sweep cycles after the first CHECK, plus CHECK and DONE.
- Same H, all-zero word with data_valid deasserted every other cycle -> load takes 127 cycles, result identical to the first test.
- Uncorrectable pattern (indices 0,1,2,3,32,33 set), MAX_ITER=2 -> success=0, iter_count=2, busy low after done.
- reset asserted mid-FLIP -> next cycle busy=0, all outputs 0.
  - A following start with a clean word decodes normally.
- start pulsed during LOAD -> ignored, load index unaffected, result matches the undisturbed run.
